// File: rtl/alarm_sequencer.sv
// Alarm buzzer sequencer: ring / snooze / timeout / lockout phases for the digital clock.
// Optional escalation to a continuous tone is enabled by defining ALARM_ESCALATE_EN.
module alarm_sequencer #(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3,
  parameter int ESCALATE_S     = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       setting_active,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer_out,
  output logic [3:0] snooze_used
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE, LOCKOUT} state_t;

  localparam logic [15:0] RING_LAST   = 16'(RING_TIMEOUT_S - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_S - 1);
  localparam logic [15:0] ESC_LEVEL   = 16'(ESCALATE_S);
  localparam logic [3:0]  MAX_USED    = 4'(MAX_SNOOZES);
`ifdef ALARM_ESCALATE_EN
  localparam bit ESCALATE_ON = 1'b1;
`else
  localparam bit ESCALATE_ON = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [15:0] ring_timer_reg, ring_timer_next;
  logic [15:0] snooze_timer_reg, snooze_timer_next;
  logic [3:0]  snooze_used_reg, snooze_used_next;
  logic        beep_phase_reg, beep_phase_next;

  logic match;
  logic trigger;

  assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min);
  assign trigger = !setting_active && match && (cur_sec == 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      ring_timer_reg   <= 16'd0;
      snooze_timer_reg <= 16'd0;
      snooze_used_reg  <= 4'd0;
      beep_phase_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ring_timer_reg   <= ring_timer_next;
      snooze_timer_reg <= snooze_timer_next;
      snooze_used_reg  <= snooze_used_next;
      beep_phase_reg   <= beep_phase_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ring_timer_next   = ring_timer_reg;
    snooze_timer_next = snooze_timer_reg;
    snooze_used_next  = snooze_used_reg;
    beep_phase_next   = beep_phase_reg;

    if (!alarm_en) begin
      // Disarming overrides every other event and wipes the per-event history.
      state_next        = IDLE;
      ring_timer_next   = 16'd0;
      snooze_timer_next = 16'd0;
      snooze_used_next  = 4'd0;
      beep_phase_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            state_next      = RINGING;
            ring_timer_next = 16'd0;
            beep_phase_next = 1'b1;
          end
        end
        RINGING: begin
          // Buttons take priority; a tick in the same cycle is dropped.
          if (stop_btn) begin
            state_next       = LOCKOUT;
            snooze_used_next = 4'd0;
          end else if (snooze_btn && (snooze_used_reg < MAX_USED)) begin
            state_next        = SNOOZE;
            snooze_used_next  = snooze_used_reg + 4'd1;
            snooze_timer_next = 16'd0;
          end else if (tick_1hz) begin
            ring_timer_next = ring_timer_reg + 16'd1;
            beep_phase_next = !beep_phase_reg;
            if (ring_timer_reg == RING_LAST) begin
              state_next       = LOCKOUT;
              snooze_used_next = 4'd0;
            end
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_next       = LOCKOUT;
            snooze_used_next = 4'd0;
          end else if (tick_1hz) begin
            snooze_timer_next = snooze_timer_reg + 16'd1;
            if (snooze_timer_reg == SNOOZE_LAST) begin
              state_next      = RINGING;
              ring_timer_next = 16'd0;
              beep_phase_next = 1'b1;
            end
          end
        end
        LOCKOUT: begin
          // Hold off until the alarm minute has passed so it cannot re-trigger.
          if (!match) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign ringing     = (state_reg == RINGING);
  assign snoozing    = (state_reg == SNOOZE);
  assign snooze_used = snooze_used_reg;
  assign buzzer_out  = ringing &&
                       (beep_phase_reg || (ESCALATE_ON && (ring_timer_reg >= ESC_LEVEL)));

endmodule
